// File: rtl/telemetry_frame_scheduler.sv
// Telemetry frame scheduler: on each enabled report tick, snapshots wheel
// speed and rotation direction and sends them to the byte-wide UART
// transmitter as a 7-byte frame. Each byte is paced against uart_busy.
// Frame layout: A5, speed[31:24], speed[23:16], speed[15:8], speed[7:0],
// {6'b0, ccw, cw}, then the XOR of bytes 1..5.
module telemetry_frame_scheduler #(
  parameter int PERIOD_CYCLES = 2700000,
  parameter int SPEED_W       = 32,
  parameter int BUSY_WAIT_MAX = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic [SPEED_W-1:0] speed,
  input  logic               dir_cw,
  input  logic               dir_ccw,
  input  logic               uart_busy,
  output logic               uart_tx_en,
  output logic [7:0]         uart_tx_data,
  output logic               frame_active,
  output logic               frame_done,
  output logic [7:0]         overrun_cnt,
  output logic               busy_err
);

  localparam int TICK_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int WAIT_W = $clog2(BUSY_WAIT_MAX + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_HI,
    WAIT_LO
  } stateT;

  stateT             r_state;
  logic [TICK_W-1:0] r_tickCnt;
  logic [2:0]        r_idx;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [31:0]       r_speedSnap;
  logic [1:0]        r_dirSnap;
  logic              r_txEn;
  logic [7:0]        r_txData;
  logic              r_frameActive;
  logic              r_frameDone;
  logic [7:0]        r_overrunCnt;
  logic              r_busyErr;

  logic              w_tick;
  logic [31:0]       w_speed32;
  logic [7:0]        w_checksum;
  logic [7:0]        w_byte;
  logic              w_waitExpired;
  logic              w_byteDone;
  logic              w_overrun;

  // The speed input is fitted to exactly 32 bits for the frame.
  generate
    if (SPEED_W >= 32) begin : g_speedTrunc
      assign w_speed32 = speed[31:0];
    end else begin : g_speedExt
      assign w_speed32 = {{(32 - SPEED_W){1'b0}}, speed};
    end
  endgenerate

  assign w_tick     = (r_tickCnt == TICK_LAST);
  assign w_checksum = r_speedSnap[31:24] ^ r_speedSnap[23:16] ^ r_speedSnap[15:8] ^
                      r_speedSnap[7:0] ^ {6'b0, r_dirSnap};

  // A byte finishes either when busy falls after rising, or when busy never
  // rose within the allowed window (the byte is then treated as sent).
  assign w_waitExpired = (r_state == WAIT_HI) && !uart_busy && (r_waitCnt == WAIT_LAST);
  assign w_byteDone    = w_waitExpired || ((r_state == WAIT_LO) && !uart_busy);

  // Ticks are dropped while a frame is in flight, including the cycle in
  // which frame_done is pulsing.
  assign w_overrun = w_tick && enable && ((r_state != IDLE) || r_frameDone);

  assign uart_tx_en   = r_txEn;
  assign uart_tx_data = r_txData;
  assign frame_active = r_frameActive;
  assign frame_done   = r_frameDone;
  assign overrun_cnt  = r_overrunCnt;
  assign busy_err     = r_busyErr;

  // Select the frame byte for the current index from the frozen snapshot.
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      3'd0:    w_byte = 8'hA5;
      3'd1:    w_byte = r_speedSnap[31:24];
      3'd2:    w_byte = r_speedSnap[23:16];
      3'd3:    w_byte = r_speedSnap[15:8];
      3'd4:    w_byte = r_speedSnap[7:0];
      3'd5:    w_byte = {6'b0, r_dirSnap};
      3'd6:    w_byte = w_checksum;
      default: w_byte = 8'h00;
    endcase
  end

  // Free-running report period counter, independent of enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tickCnt <= '0;
    end else if (w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + TICK_W'(1);
    end
  end

  // Frame sequencer: snapshot on tick, then strobe/wait-high/wait-low per byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_idx         <= 3'd0;
      r_waitCnt     <= '0;
      r_speedSnap   <= 32'h0;
      r_dirSnap     <= 2'b00;
      r_txEn        <= 1'b0;
      r_txData      <= 8'h00;
      r_frameActive <= 1'b0;
      r_frameDone   <= 1'b0;
      r_overrunCnt  <= 8'h00;
      r_busyErr     <= 1'b0;
    end else begin
      r_txEn      <= 1'b0;
      r_frameDone <= 1'b0;

      if (w_overrun && (r_overrunCnt != 8'hFF)) begin
        r_overrunCnt <= r_overrunCnt + 8'd1;
      end

      case (r_state)
        IDLE: begin
          if (w_tick && enable && !r_frameDone) begin
            r_speedSnap   <= w_speed32;
            r_dirSnap     <= {dir_ccw, dir_cw};
            r_idx         <= 3'd0;
            r_frameActive <= 1'b1;
            r_state       <= STROBE;
          end
        end
        STROBE: begin
          if (!uart_busy) begin
            r_txEn    <= 1'b1;
            r_txData  <= w_byte;
            r_waitCnt <= '0;
            r_state   <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (uart_busy) begin
            r_state <= WAIT_LO;
          end else if (w_waitExpired) begin
            r_busyErr <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
          end
        end
        WAIT_LO: begin
          r_state <= WAIT_LO;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      if (w_byteDone) begin
        if (r_idx == 3'd6) begin
          r_frameDone   <= 1'b1;
          r_frameActive <= 1'b0;
          r_state       <= IDLE;
        end else begin
          r_idx   <= r_idx + 3'd1;
          r_state <= STROBE;
        end
      end
    end
  end

endmodule

// File: tb/tb_telemetry_frame_scheduler.sv
// Testbench for telemetry_frame_scheduler. The stimulus process predicts
// whole frames and overrun counts from the frame rules and the bench's own
// busy-response timing, and queues expected bytes. A separate monitor pops
// and compares the queued bytes on every strobe.
module tb_telemetry_frame_scheduler;

  localparam int PERIOD  = 64;
  localparam int WAITMAX = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        enable;
  logic [31:0] speed;
  logic        dir_cw;
  logic        dir_ccw;
  logic        uart_busy;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        frame_active;
  logic        frame_done;
  logic [7:0]  overrun_cnt;
  logic        busy_err;

  int          checks = 0;
  int          errors = 0;

  logic [8:0]  expQ[$];
  logic [8:0]  monExp;
  bit          pendingDone = 1'b0;
  int          busyLen = 0;
  int          busyRemain = 0;

  telemetry_frame_scheduler #(
    .PERIOD_CYCLES(PERIOD),
    .SPEED_W(32),
    .BUSY_WAIT_MAX(WAITMAX)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .enable(enable),
    .speed(speed),
    .dir_cw(dir_cw),
    .dir_ccw(dir_ccw),
    .uart_busy(uart_busy),
    .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .frame_active(frame_active),
    .frame_done(frame_done),
    .overrun_cnt(overrun_cnt),
    .busy_err(busy_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Builds the expected 7-byte frame from the sampled inputs and queues it.
  task automatic pushFrame(input logic [31:0] spd, input logic cw, input logic ccw);
    logic [7:0] b[7];
    b[0] = 8'hA5;
    for (int i = 0; i < 4; i++) b[1+i] = 8'((spd >> (24 - 8 * i)) & 32'hFF);
    b[5] = {6'b0, ccw, cw};
    b[6] = 8'h00;
    for (int i = 1; i <= 5; i++) b[6] = b[6] ^ b[i];
    for (int i = 0; i < 7; i++) expQ.push_back({(i == 6), b[i]});
  endtask

  // Transmitter stand-in: busy rises right after a strobe and lasts busyLen
  // cycles; busyLen of zero models a transmitter whose busy never rises.
  always @(posedge CLK) begin
    #1;
    if (RST) begin
      uart_busy  = 1'b0;
      busyRemain = 0;
    end else begin
      if (busyRemain > 0) begin
        busyRemain--;
        if (busyRemain == 0) uart_busy = 1'b0;
      end
      if (uart_tx_en && busyLen > 0) begin
        uart_busy  = 1'b1;
        busyRemain = busyLen;
      end
    end
  end

  // Monitor: every strobe must match the next queued byte, and frame_done
  // must follow the last byte of each frame exactly once.
  always @(posedge CLK) begin
    #1;
    if (!RST) begin
      if (uart_tx_en) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_strobe: got data 0x%0h, expected no strobe", uart_tx_data);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("strobe_data", uart_tx_data, monExp[7:0]);
          checkOutput("active_at_strobe", frame_active, 1);
          if (monExp[8]) begin
            checkOutput("done_before_next_frame", pendingDone, 0);
            pendingDone = 1'b1;
          end
        end
      end
      if (frame_done) begin
        checkOutput("frame_done_after_last", pendingDone, 1);
        checkOutput("active_at_done", frame_active, 0);
        pendingDone = 1'b0;
      end
    end
  end

  // Holds reset for n edges, then checks every output is cleared.
  task automatic applyReset(input int n);
    RST = 1'b1;
    repeat (n) @(negedge CLK);
    checkOutput("rst_tx_en", uart_tx_en, 0);
    checkOutput("rst_tx_data", uart_tx_data, 0);
    checkOutput("rst_frame_active", frame_active, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_overrun_cnt", overrun_cnt, 0);
    checkOutput("rst_busy_err", busy_err, 0);
    RST = 1'b0;
  endtask

  // Fresh random inputs every cycle, so a snapshot is always followed by changes.
  task automatic applyStimulus();
    speed   = $urandom;
    dir_cw  = 1'($urandom_range(0, 1));
    dir_ccw = 1'($urandom_range(0, 1));
    enable  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int  c;
    int  tickIdx;
    int  dropped;
    int  ovModel;
    int  busyUntil;
    int  perByte;
    int  len;
    int  strobeCnt;
    bit  en;
    bit  startedLast;
    bit  resetArmed;
    bit  finished;

    RST       = 1'b1;
    enable    = 1'b0;
    speed     = 32'h0;
    dir_cw    = 1'b0;
    dir_ccw   = 1'b0;
    uart_busy = 1'b0;

    applyReset(3);
    c           = 0;
    tickIdx     = 0;
    dropped     = 0;
    ovModel     = 0;
    busyUntil   = -1000;
    strobeCnt   = 0;
    startedLast = 1'b0;
    resetArmed  = 1'b0;
    finished    = 1'b0;

    for (int cyc = 0; cyc < 60000 && !finished; cyc++) begin
      @(negedge CLK);
      c++;
      if (uart_tx_en) strobeCnt++;

      if (resetArmed && strobeCnt == 4) begin
        resetArmed = 1'b0;
        @(negedge CLK);
        applyReset(1);
        expQ.delete();
        c         = 0;
        busyUntil = -1000;
        ovModel   = 0;
        dropped   = 0;
        continue;
      end

      applyStimulus();

      if (c % PERIOD == PERIOD - 1) begin
        tickIdx++;
        checkOutput("overrun_cnt", overrun_cnt, ovModel);
        if (tickIdx == 17) checkOutput("busy_err_before_stuck", busy_err, 0);
        if (tickIdx == 21) checkOutput("busy_err_after_stuck", busy_err, 1);

        if (tickIdx <= 8) begin
          len = 3;
          en  = (tickIdx <= 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
          if (tickIdx == 1) begin
            speed = 32'h0000_1234; dir_cw = 1'b1; dir_ccw = 1'b0;
          end
          if (tickIdx == 2) begin
            speed = 32'hFFFF_FFFF; dir_cw = 1'b1; dir_ccw = 1'b0;
          end
        end else if (tickIdx <= 16) begin
          len = 10;
          en  = 1'b1;
        end else if (tickIdx <= 24) begin
          len = 0;
          en  = !startedLast;
        end else if (tickIdx <= 28) begin
          len = 3;
          en  = 1'b1;
        end else begin
          len = 185;
          en  = (dropped < 300);
        end
        enable = en;

        startedLast = 1'b0;
        if (en) begin
          if (c + 1 > busyUntil) begin
            pushFrame(speed, dir_cw, dir_ccw);
            busyLen     = len;
            perByte     = (len > 0) ? len + 2 : WAITMAX + 1;
            busyUntil   = c + 1 + 7 * perByte + 1;
            startedLast = 1'b1;
            strobeCnt   = 0;
            if (tickIdx == 25) resetArmed = 1'b1;
          end else begin
            dropped++;
            if (ovModel < 255) ovModel++;
          end
        end
      end

      if (tickIdx > 28 && dropped >= 300 && c > busyUntil + 4) finished = 1'b1;
    end

    checkOutput("run_completed", finished, 1);
    checkOutput("queue_empty", expQ.size(), 0);
    checkOutput("no_pending_done", pendingDone, 0);
    checkOutput("overrun_saturated", overrun_cnt, 255);
    checkOutput("idle_frame_active", frame_active, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/telemetry_frame_scheduler.md
Name: telemetry_frame_scheduler

Overview:
- Periodically snapshots wheel speed and rotation direction, then sequences them as a fixed 7-byte frame into the byte-wide uart_tx transmitter.
- Owns the uart_tx_en / uart_tx_data side of the transmitter and paces each byte against uart_busy.
- Sits between the wheel_speed / direction_of_rotation blocks and uart_tx in the top level.

Parameters:
- PERIOD_CYCLES, 2700000, CLK cycles between report ticks (10 Hz at 27 MHz); minimum 64.
- SPEED_W, 32, width of the speed input; zero-extended or truncated to 32 bits for the frame.
- BUSY_WAIT_MAX, 8, CLK cycles allowed for uart_busy to rise after a strobe.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- enable  in  1  when 1, report ticks start frames
- speed  in  SPEED_W  wheel speed value, sampled at frame start
- dir_cw  in  1  clockwise indication
- dir_ccw  in  1  counter-clockwise indication
- uart_busy  in  1  transmitter busy
- uart_tx_en  out  1  one-cycle byte strobe to the transmitter
- uart_tx_data  out  8  byte presented to the transmitter
- frame_active  out  1  high from frame start until the last byte completes
- frame_done  out  1  one-cycle pulse when the last byte completes
- overrun_cnt  out  8  saturating count of ticks dropped because a frame was in flight
- busy_err  out  1  sticky flag, set when uart_busy failed to rise within BUSY_WAIT_MAX

Behaviour:
- Reset (RST=1 at posedge): all outputs 0, tick counter 0, byte index 0, state IDLE. This applies mid-frame as well: the frame is abandoned and no further strobe is issued.
- Tick counter:
  - Free-runs 0..PERIOD_CYCLES-1 and wraps to 0, independent of enable.
  - tick=1 in the cycle where the count equals PERIOD_CYCLES-1.
- Frame format (bytes B0..B6), built from a snapshot taken at the starting tick edge:
  - B0 = 0xA5.
  - B1..B4 = speed[31:0], MSB first.
  - B5 = {6'b0, dir_ccw, dir_cw}.
  - B6 = B1^B2^B3^B4^B5.
  - Inputs that change after the snapshot do not affect the frame.
- States: IDLE, STROBE, WAIT_HI, WAIT_LO.
  - IDLE: if tick and enable, capture the snapshot, set idx=0, set frame_active=1, go to STROBE. A tick with enable=0 is ignored and not counted.
  - STROBE: if uart_busy=0, drive uart_tx_en=1 for exactly this cycle with uart_tx_data=B[idx], clear the wait counter, go to WAIT_HI. Otherwise stay in STROBE with uart_tx_en=0.
  - WAIT_HI: if uart_busy=1, go to WAIT_LO. Otherwise increment the wait counter. When it reaches BUSY_WAIT_MAX, set busy_err=1 and treat the byte as sent (same path as WAIT_LO completion).
  - WAIT_LO: when uart_busy=0, the byte is complete:
    - If idx<6: idx+1, go to STROBE.
    - If idx==6: frame_done=1 for one cycle, frame_active=0 in the same cycle, go to IDLE.
- Overruns:
  - A tick arriving while the state is not IDLE (with enable=1) is dropped and increments overrun_cnt, which saturates at 255.
  - A tick in the exact cycle frame_done pulses is also dropped and counted. The next frame can start no earlier than the following tick.
- enable falling mid-frame does not abort; the frame completes.
- uart_tx_data holds its value between strobes; it changes only on a strobe or on reset.
- Minimum strobe spacing: 3 cycles (STROBE, WAIT_HI, WAIT_LO), even if busy pulses are 1 cycle.
- busy_err and overrun_cnt clear only on RST.

Test Plan:
1. PERIOD_CYCLES=64; speed=0x00001234, dir_cw=1, dir_ccw=0, enable=1; busy model rises 1 cycle after strobe and lasts 10 cycles -> 7 strobes with data A5,00,00,12,34,01,27. frame_done fires once, one cycle after busy falls after byte 6, and frame_active spans it.
2. Snapshot freeze: change speed to 0xFFFFFFFF one cycle after tick -> frame still carries 00,00,12,34. The next frame carries FF,FF,FF,FF with checksum 0x01^0x00 = 0x01 when dir_cw=1.
3. Overrun: busy lasts 20 cycles per byte, PERIOD_CYCLES=64 -> ticks during the frame increment overrun_cnt. Extend the run to 300 dropped ticks -> overrun_cnt=255.
4. Busy stuck low: uart_busy held 0 -> each byte advances after BUSY_WAIT_MAX waits and busy_err=1. All 7 strobes are still issued, and frame_done is asserted.
5. Reset mid-frame: assert RST during WAIT_LO of byte 3 -> next cycle all outputs 0 and state IDLE. No further strobe occurs until the next tick after RST is released.
6. enable=0 at tick -> no strobe and overrun_cnt unchanged. Dropping enable during byte 2 -> the frame still completes with 7 bytes.
